// File: rtl/serializer_tx.sv
// serializer_tx: parallel-to-serial converter for the phy_tx path.
// Takes WIDTH-bit words over valid/ready and shifts them out one bit per dclk
// with no gaps; when no payload is offered at a word boundary the IDLE_WORD
// comma fill goes out instead. tx_en only takes effect at word boundaries.
//
// Handshake: a word moves from the source into the block on a rising dclk
// edge where data_valid && data_ready. data_ready is combinational and only
// high at a word boundary with tx_en=1 and reset low. While data_valid=1 and
// data_ready=0 the source holds data_in stable; data_valid may not be
// withdrawn-and-changed before acceptance.
module serializer_tx #(
  parameter int               WIDTH     = 8,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'('hBC),
  parameter int               CW        = $clog2(WIDTH)
) (
  input  logic             dclk,
  input  logic             default_values,
  input  logic             tx_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             data_out,
  output logic [CW-1:0]    cnt,
  output logic             word_start,
  output logic             sending_data
);

  typedef enum logic {
    ST_OFF    = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0]    cnt_d;
  logic             dout_d;
  logic             ws_d;
  logic             sd_d;
  logic             boundary;
  logic             transfer;
  logic [WIDTH-1:0] load_word;

  // A new word (or the decision to go quiet) is only taken when the line is
  // off or the last bit of the current word is on data_out.
  assign boundary   = (state == ST_OFF) || (cnt == CNT_LAST);
  assign data_ready = boundary && tx_en && !default_values;
  assign transfer   = data_valid && data_ready;
  assign load_word  = transfer ? data_in : IDLE_WORD;

  // Next-state and next-output logic; shreg holds the bits still to be sent.
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    cnt_d   = cnt;
    dout_d  = data_out;
    ws_d    = 1'b0;
    sd_d    = sending_data;
    if (boundary) begin
      if (!tx_en) begin
        state_d = ST_OFF;
        cnt_d   = CNT_LAST;
        dout_d  = 1'b0;
        sd_d    = 1'b0;
      end else begin
        state_d = ST_ACTIVE;
        cnt_d   = '0;
        ws_d    = 1'b1;
        sd_d    = transfer;
        if (MSB_FIRST) begin
          dout_d  = load_word[WIDTH-1];
          shreg_d = load_word << 1;
        end else begin
          dout_d  = load_word[0];
          shreg_d = load_word >> 1;
        end
      end
    end else begin
      // Mid-word: tx_en and data_valid are ignored so a word is never cut short.
      cnt_d = cnt + CW'(1);
      if (MSB_FIRST) begin
        dout_d  = shreg[WIDTH-1];
        shreg_d = shreg << 1;
      end else begin
        dout_d  = shreg[0];
        shreg_d = shreg >> 1;
      end
    end
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge dclk) begin
    if (default_values) begin
      state        <= ST_OFF;
      shreg        <= '0;
      cnt          <= CNT_LAST;
      data_out     <= 1'b0;
      word_start   <= 1'b0;
      sending_data <= 1'b0;
    end else begin
      state        <= state_d;
      shreg        <= shreg_d;
      cnt          <= cnt_d;
      data_out     <= dout_d;
      word_start   <= ws_d;
      sending_data <= sd_d;
    end
  end

endmodule

// File: tb/tb_serializer_tx.sv
// Bench for serializer_tx: an 8-bit MSB-first instance and a 10-bit
// LSB-first instance, each with its own expected-output queue.
module tb_serializer_tx;

  // ---------------- clock / reset ----------------
  logic dclk;
  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  logic       rst8, en8, vld8, rdy8, do8, ws8, sd8;
  logic [7:0] din8;
  logic [2:0] cnt8;
  logic       rst10, en10, vld10, rdy10, do10, ws10, sd10;
  logic [9:0] din10;
  logic [3:0] cnt10;

  initial begin
    rst8 = 1'b1; en8 = 1'b0; vld8 = 1'b0; din8 = '0;
    rst10 = 1'b1; en10 = 1'b0; vld10 = 1'b0; din10 = '0;
  end

  serializer_tx dut8 (
    .dclk(dclk), .default_values(rst8), .tx_en(en8), .data_in(din8),
    .data_valid(vld8), .data_ready(rdy8), .data_out(do8), .cnt(cnt8),
    .word_start(ws8), .sending_data(sd8)
  );

  serializer_tx #(.WIDTH(10), .MSB_FIRST(1'b0), .IDLE_WORD(10'h17C)) dut10 (
    .dclk(dclk), .default_values(rst10), .tx_en(en10), .data_in(din10),
    .data_valid(vld10), .data_ready(rdy10), .data_out(do10), .cnt(cnt10),
    .word_start(ws10), .sending_data(sd10)
  );

  // ---------------- scoreboard ----------------
  // One record per output cycle: {sending_data, word_start, cnt[4:0], data_out}
  logic [7:0] exp8_q[$];
  logic [7:0] exp10_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? exp8_q.size() : exp10_q.size();
  endfunction

  function automatic logic [7:0] qpop(input int d);
    if (d == 0) return exp8_q.pop_front();
    return exp10_q.pop_front();
  endfunction

  function automatic void qpush(input int d, input logic [7:0] r);
    if (d == 0) exp8_q.push_back(r);
    else exp10_q.push_back(r);
  endfunction

  function automatic void qclear(input int d);
    if (d == 0) exp8_q.delete();
    else exp10_q.delete();
  endfunction

  function automatic logic [7:0] act_rec(input int d);
    if (d == 0) return {sd8, ws8, 5'(cnt8), do8};
    return {sd10, ws10, 5'(cnt10), do10};
  endfunction

  // ---------------- driver ----------------
  // One dclk cycle: compare the outputs now on the line against the queue,
  // drive inputs for the coming edge, check data_ready, and queue what the
  // coming edge must produce. An empty queue after the pop means the current
  // cycle is a word boundary (last bit on the line, or line off).
  task automatic cyc(input int d, input logic r, input logic e, input logic v,
                     input logic [9:0] w, output logic acc);
    logic [7:0] rec;
    logic       bnd;
    logic [9:0] word;
    int         wd;
    logic       msb;
    wd  = (d == 0) ? 8 : 10;
    msb = (d == 0);
    @(negedge dclk);
    if (qsize(d) != 0) begin
      rec = qpop(d);
      check((d == 0) ? "out8" : "out10", {24'd0, act_rec(d)}, {24'd0, rec});
    end
    bnd = (qsize(d) == 0);
    if (d == 0) begin
      rst8 = r; en8 = e; vld8 = v; din8 = w[7:0];
    end else begin
      rst10 = r; en10 = e; vld10 = v; din10 = w;
    end
    #1;
    check((d == 0) ? "ready8" : "ready10", {31'd0, (d == 0) ? rdy8 : rdy10},
          {31'd0, bnd && e && !r});
    acc = bnd && e && v && !r;
    if (r) begin
      qclear(d);
      qpush(d, {2'b00, 5'(wd - 1), 1'b0});
    end else if (bnd) begin
      if (!e) begin
        qpush(d, {2'b00, 5'(wd - 1), 1'b0});
      end else begin
        word = v ? w : ((d == 0) ? 10'h0BC : 10'h17C);
        for (int k = 0; k < wd; k++)
          qpush(d, {v, (k == 0), 5'(k), msb ? word[wd-1-k] : word[k]});
      end
    end
  endtask

  task automatic idle(input int d, input int n, input logic e);
    logic acc;
    repeat (n) cyc(d, 1'b0, e, 1'b0, 10'd0, acc);
  endtask

  task automatic reset_dut(input int d, input int n);
    logic acc;
    repeat (n) cyc(d, 1'b1, 1'b0, 1'b0, 10'd0, acc);
  endtask

  // Offer a word and hold it until accepted (bounded wait).
  task automatic send(input int d, input logic [9:0] w);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 40) begin
      cyc(d, 1'b0, 1'b1, 1'b1, w, acc);
      n++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic random_run(input int d, input int n);
    logic       pv, e, acc;
    logic [9:0] pw;
    pv = 1'b0;
    pw = '0;
    for (int i = 0; i < n; i++) begin
      if (!pv) begin
        pv = 1'($urandom_range(0, 1));
        pw = 10'($urandom_range(0, 1023));
      end
      e = ($urandom_range(0, 3) != 0);
      cyc(d, 1'b0, e, pv, pw, acc);
      if (acc) pv = 1'b0;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // 8-bit, MSB first
    reset_dut(0, 2);
    send(0, 10'h0A5);          // single payload word
    idle(0, 20, 1'b1);         // then comma fill repeats
    send(0, 10'h0A5);          // back-to-back payload
    send(0, 10'h03C);
    idle(0, 10, 1'b1);
    send(0, 10'h0A5);          // drop tx_en at cnt=3
    idle(0, 3, 1'b1);
    idle(0, 8, 1'b0);
    send(0, 10'h05A);          // accepted straight out of OFF
    idle(0, 9, 1'b1);
    send(0, 10'h0C3);          // reset at cnt=4 of a payload word
    idle(0, 4, 1'b1);
    reset_dut(0, 1);
    idle(0, 12, 1'b1);
    random_run(0, 120);
    idle(0, 10, 1'b0);

    // 10-bit, LSB first, fill 10'h17C
    reset_dut(1, 2);
    send(1, 10'h2A5);
    idle(1, 22, 1'b1);
    random_run(1, 120);
    idle(1, 12, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
